// File: rtl/sctag_vuad_byp_ctl.sv
// rtl/sctag_vuad_byp_ctl.sv - VUAD valid/dirty bypass select control for C1 array reads
// Optional SCTAG_VUAD_BYP_PERF_EN adds byp_cnt, a saturating count of bypassed C1 reads.
module sctag_vuad_byp_ctl #(
  parameter int IDX_W = 10
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             si,
  input  logic             se,
  output logic             so,
  input  logic             inst_vld_c1,
  input  logic             vd_wen_c1,
  input  logic [IDX_W-1:0] idx_c1,
  input  logic             diag_vd_wr_c1,
  output logic             vuad_sel_rd,
  output logic             vuad_sel_c2,
  output logic             vuad_sel_c2orc3,
  output logic             vuad_sel_c4,
  output logic             vuad_sel_c2_d1,
  output logic             sel_vd_wr_data_byp,
  output logic             bistordiag_wr_vd_c4
`ifdef SCTAG_VUAD_BYP_PERF_EN
  ,
  output logic [15:0]      byp_cnt
`endif
);

  // Every flop lives in one packed state word so the scan chain is a plain shift of it.
  typedef struct packed {
`ifdef SCTAG_VUAD_BYP_PERF_EN
    logic [15:0]      cnt;
`endif
    logic [IDX_W-1:0] idx_c6;
    logic [IDX_W-1:0] idx_c5;
    logic [IDX_W-1:0] idx_c4;
    logic [IDX_W-1:0] idx_c3;
    logic [IDX_W-1:0] idx_c2;
    logic             wv_c6;
    logic             wv_c5;
    logic             wv_c4;
    logic             wv_c3;
    logic             wv_c2;
    logic             diag_c4;
    logic             diag_c3;
    logic             diag_c2;
    logic             sel_c2_d1;
    logic             sel_byp;
  } st_t;

  localparam int ST_W = $bits(st_t);

  st_t  st_q;
  st_t  st_d;
  logic m_c2;
  logic m_c3;
  logic m_c4;
  logic m_c5;

  assign m_c2 = inst_vld_c1 & st_q.wv_c2 & (idx_c1 == st_q.idx_c2);
  assign m_c3 = inst_vld_c1 & st_q.wv_c3 & (idx_c1 == st_q.idx_c3);
  assign m_c4 = inst_vld_c1 & st_q.wv_c4 & (idx_c1 == st_q.idx_c4);
  assign m_c5 = inst_vld_c1 & st_q.wv_c5 & (idx_c1 == st_q.idx_c5);

  // Youngest in-flight writer wins.
  assign vuad_sel_c2         = m_c2;
  assign vuad_sel_c2orc3     = m_c2 | m_c3;
  assign vuad_sel_c4         = m_c4 & ~(m_c2 | m_c3);
  assign vuad_sel_rd         = ~(m_c2 | m_c3 | m_c4 | m_c5);
  assign vuad_sel_c2_d1      = st_q.sel_c2_d1;
  assign sel_vd_wr_data_byp  = st_q.sel_byp;
  assign bistordiag_wr_vd_c4 = st_q.diag_c4;
  assign so                  = st_q[ST_W-1];
`ifdef SCTAG_VUAD_BYP_PERF_EN
  assign byp_cnt             = st_q.cnt;
`endif

  always_comb begin
    st_d           = st_q;
    st_d.idx_c2    = idx_c1;
    st_d.idx_c3    = st_q.idx_c2;
    st_d.idx_c4    = st_q.idx_c3;
    st_d.idx_c5    = st_q.idx_c4;
    st_d.idx_c6    = st_q.idx_c5;
    st_d.wv_c2     = inst_vld_c1 & vd_wen_c1;
    st_d.wv_c3     = st_q.wv_c2;
    st_d.wv_c4     = st_q.wv_c3;
    st_d.wv_c5     = st_q.wv_c4;
    st_d.wv_c6     = st_q.wv_c5;
    st_d.diag_c2   = diag_vd_wr_c1;
    st_d.diag_c3   = st_q.diag_c2;
    st_d.diag_c4   = st_q.diag_c3;
    st_d.sel_c2_d1 = m_c2;
    // Reader reaches C2 as the C5 writer reaches C6 and drives its write data.
    st_d.sel_byp   = m_c5;
`ifdef SCTAG_VUAD_BYP_PERF_EN
    if (inst_vld_c1 & ~vuad_sel_rd & (st_q.cnt != 16'hFFFF))
      st_d.cnt = st_q.cnt + 16'd1;
`endif
    // Index registers keep shifting through reset; they are ignored while wv is 0.
    if (reset) begin
      st_d.wv_c2     = 1'b0;
      st_d.wv_c3     = 1'b0;
      st_d.wv_c4     = 1'b0;
      st_d.wv_c5     = 1'b0;
      st_d.wv_c6     = 1'b0;
      st_d.diag_c2   = 1'b0;
      st_d.diag_c3   = 1'b0;
      st_d.diag_c4   = 1'b0;
      st_d.sel_c2_d1 = 1'b0;
      st_d.sel_byp   = 1'b0;
`ifdef SCTAG_VUAD_BYP_PERF_EN
      st_d.cnt       = 16'd0;
`endif
    end
  end

  always_ff @(posedge rclk) begin
    if (se)
      st_q <= {st_q[ST_W-2:0], si};
    else
      st_q <= st_d;
  end

endmodule

// File: tb/tb_sctag_vuad_byp_ctl.sv
// tb/tb_sctag_vuad_byp_ctl.sv - self-checking bench for sctag_vuad_byp_ctl
// Build with SCTAG_VUAD_BYP_PERF_EN defined to also check byp_cnt.
module tb_sctag_vuad_byp_ctl;

  logic       rclk = 1'b0;
  logic       reset, si, se, so;
  logic       inst_vld_c1, vd_wen_c1, diag_vd_wr_c1;
  logic [9:0] idx_c1;
  logic       vuad_sel_rd, vuad_sel_c2, vuad_sel_c2orc3, vuad_sel_c4;
  logic       vuad_sel_c2_d1, sel_vd_wr_data_byp, bistordiag_wr_vd_c4;
`ifdef SCTAG_VUAD_BYP_PERF_EN
  logic [15:0] byp_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 rclk = ~rclk;

  sctag_vuad_byp_ctl #(.IDX_W(10)) dut (
    .rclk(rclk), .reset(reset), .si(si), .se(se), .so(so),
    .inst_vld_c1(inst_vld_c1), .vd_wen_c1(vd_wen_c1), .idx_c1(idx_c1),
    .diag_vd_wr_c1(diag_vd_wr_c1),
    .vuad_sel_rd(vuad_sel_rd), .vuad_sel_c2(vuad_sel_c2),
    .vuad_sel_c2orc3(vuad_sel_c2orc3), .vuad_sel_c4(vuad_sel_c4),
    .vuad_sel_c2_d1(vuad_sel_c2_d1), .sel_vd_wr_data_byp(sel_vd_wr_data_byp),
    .bistordiag_wr_vd_c4(bistordiag_wr_vd_c4)
`ifdef SCTAG_VUAD_BYP_PERF_EN
    , .byp_cnt(byp_cnt)
`endif
  );

  typedef struct {
    logic       rst, vld, wen;
    logic [9:0] idx;
    logic       diag;
    logic       rd, c2, c23, c4, d1, byp, bd;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic add(input logic rst, vld, wen, input logic [9:0] idx, input logic diag,
                     input logic rd, c2, c23, c4, d1, byp, bd);
    vec_t v;
    v.rst = rst; v.vld = vld; v.wen = wen; v.idx = idx; v.diag = diag;
    v.rd = rd; v.c2 = c2; v.c23 = c23; v.c4 = c4; v.d1 = d1; v.byp = byp; v.bd = bd;
    tbl.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(0, 0, 0, 10'h000, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int t, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, t, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, vld, wen, input logic [9:0] idx, input logic diag);
    reset = rst; inst_vld_c1 = vld; vd_wen_c1 = wen; idx_c1 = idx; diag_vd_wr_c1 = diag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    si = 1'b0; se = 1'b0;
    drive(1, 0, 0, 10'h000, 0);
    repeat (2) @(posedge rclk);
    #1 drive(0, 0, 0, 10'h000, 0);
    @(negedge rclk);
    chk("reset_rd", -1, vuad_sel_rd, 1'b1);
    chk("reset_c2", -1, vuad_sel_c2, 1'b0);
    chk("reset_c2orc3", -1, vuad_sel_c2orc3, 1'b0);
    chk("reset_c4", -1, vuad_sel_c4, 1'b0);
    chk("reset_c2_d1", -1, vuad_sel_c2_d1, 1'b0);
    chk("reset_byp", -1, sel_vd_wr_data_byp, 1'b0);
    chk("reset_diag", -1, bistordiag_wr_vd_c4, 1'b0);

    //   rst vld wen idx      diag | rd c2 c23 c4 d1 byp bd
    add(0, 1, 0, 10'h055, 0,  1, 0, 0, 0, 0, 0, 0);   // t0 plain read after reset
    add(0, 1, 1, 10'h055, 0,  1, 0, 0, 0, 0, 0, 0);   // t1 writer
    add(0, 1, 0, 10'h055, 0,  0, 1, 1, 0, 0, 0, 0);   // t2 reader hits C2
    add(0, 0, 0, 10'h000, 0,  1, 0, 0, 0, 1, 0, 0);   // t3 c2_d1 follows
    idle(4);                                           // t4-t7
    add(0, 1, 1, 10'h055, 0,  1, 0, 0, 0, 0, 0, 0);   // t8 writer
    idle(1);                                           // t9
    add(0, 1, 1, 10'h055, 0,  0, 0, 1, 0, 0, 0, 0);   // t10 writer, hits t8 in C3
    add(0, 1, 0, 10'h055, 0,  0, 1, 1, 0, 0, 0, 0);   // t11 C2 beats C4
    add(0, 0, 0, 10'h000, 0,  1, 0, 0, 0, 1, 0, 0);   // t12
    idle(3);                                           // t13-t15
    add(0, 1, 1, 10'h055, 0,  1, 0, 0, 0, 0, 0, 0);   // t16 writer
    idle(2);                                           // t17-t18
    add(0, 1, 0, 10'h055, 0,  0, 0, 0, 1, 0, 0, 0);   // t19 C4 only
    idle(2);                                           // t20-t21
    add(0, 1, 1, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 0);   // t22 writer
    idle(3);                                           // t23-t25
    add(0, 1, 0, 10'h1A0, 0,  0, 0, 0, 0, 0, 0, 0);   // t26 C5 bypass
    add(0, 0, 0, 10'h000, 0,  1, 0, 0, 0, 0, 1, 0);   // t27 C6 write-data bypass
    idle(1);                                           // t28
    add(0, 1, 1, 10'h1A1, 0,  1, 0, 0, 0, 0, 0, 0);   // t29 writer other index
    add(0, 1, 0, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 0);   // t30 miss on index
    add(0, 1, 0, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 0);   // t31 vd_wen=0 "writer"
    add(0, 1, 0, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 0);   // t32 miss on wen
    add(0, 1, 1, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 0);   // t33 writer
    add(1, 0, 0, 10'h000, 0,  1, 0, 0, 0, 0, 0, 0);   // t34 reset mid-flight
    add(0, 1, 0, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 0);   // t35 tracking discarded
    add(0, 1, 0, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 0);   // t36
    add(0, 0, 0, 10'h000, 1,  1, 0, 0, 0, 0, 0, 0);   // t37 diag pulse
    add(0, 1, 0, 10'h3FF, 0,  1, 0, 0, 0, 0, 0, 0);   // t38
    add(0, 1, 0, 10'h000, 0,  1, 0, 0, 0, 0, 0, 0);   // t39
    add(0, 1, 0, 10'h1A0, 0,  1, 0, 0, 0, 0, 0, 1);   // t40 diag in C4
    add(0, 1, 0, 10'h2AA, 0,  1, 0, 0, 0, 0, 0, 0);   // t41

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge rclk);
      #1 drive(tbl[i].rst, tbl[i].vld, tbl[i].wen, tbl[i].idx, tbl[i].diag);
      sb.push_back(tbl[i]);
      @(negedge rclk);
      e = sb.pop_front();
      chk("vuad_sel_rd", i, vuad_sel_rd, e.rd);
      chk("vuad_sel_c2orc3", i, vuad_sel_c2orc3, e.c23);
      if (e.c23) chk("vuad_sel_c2", i, vuad_sel_c2, e.c2);
      else       chk("vuad_sel_c4", i, vuad_sel_c4, e.c4);
      chk("vuad_sel_c2_d1", i, vuad_sel_c2_d1, e.d1);
      chk("sel_vd_wr_data_byp", i, sel_vd_wr_data_byp, e.byp);
      chk("bistordiag_wr_vd_c4", i, bistordiag_wr_vd_c4, e.bd);
    end

    // Three consecutive bypassed reads of one writer (C2, C3, C4).
    @(posedge rclk); #1 drive(1, 0, 0, 10'h000, 0);
    @(posedge rclk); #1 drive(0, 1, 1, 10'h055, 0);
    @(negedge rclk); chk("seq_writer_rd", 0, vuad_sel_rd, 1'b1);
    for (int u = 1; u <= 3; u++) begin
      @(posedge rclk); #1 drive(0, 1, 0, 10'h055, 0);
      @(negedge rclk); chk("seq_reader_rd", u, vuad_sel_rd, 1'b0);
    end
    @(posedge rclk); #1 drive(0, 0, 0, 10'h000, 0);
    @(negedge rclk); chk("seq_idle_rd", 4, vuad_sel_rd, 1'b1);
`ifdef SCTAG_VUAD_BYP_PERF_EN
    chk16("byp_cnt", byp_cnt, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
